// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared FSM state encoding and default SIZE/DIV for shift_ctrl
package shift_ctrl_pkg;
   localparam int SIZE_DEF = 8;
   localparam int DIV_DEF = 4;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_ctrl_bit_tick_gen.sv
// bit_tick_gen: DIV-cycle prescaler; ports clk, rst, clr (restart count), en (count), tick (pulse on DIV-th enabled cycle)
module bit_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int W = DIV > 1 ? $clog2(DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = en && cnt == W'(DIV - 1);
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: word-to-shift-register sequencer (IDLE/LOAD/SHIFT/DONE) issuing Load, DIV-spaced Shift strobes and Done.
// Ports: Clk, Rst (sync, active high), Valid/Data/Ready upstream handshake; Load, Shift, DataOut to the shift register;
// Busy while serialising, Done one-cycle end-of-word pulse. Macro SHIFT_CTRL_BUF_EN adds a one-word holding buffer.
module shift_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int SIZE = SIZE_DEF,
   parameter int DIV = DIV_DEF
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            Valid,
   input  logic [SIZE-1:0] Data,
   output logic            Ready,
   output logic            Load,
   output logic            Shift,
   output logic [SIZE-1:0] DataOut,
   output logic            Busy,
   output logic            Done
);
   localparam int BW = $clog2(SIZE + 1);
   state_t state;
   logic [BW-1:0] bits;
   logic accept, tick, en, go_load, last;
   assign accept = Valid && Ready;
   assign last = bits == BW'(SIZE);
   // the prescaler runs from LOAD onward so the first Shift lands DIV cycles after Load
   assign en = state == LOAD || (state == SHIFT && !last);
`ifdef SHIFT_CTRL_BUF_EN
   logic [SIZE-1:0] buf_word;
   logic buf_full, drain, store, full_next;
   // an idle drain covers a word buffered during the final DONE cycle
   assign drain = buf_full && (state == IDLE || state == DONE);
   assign go_load = drain || (accept && state == IDLE);
   assign store = accept && state != IDLE;
   assign full_next = store || (buf_full && !drain);
`else
   assign go_load = accept && state == IDLE;
`endif
   bit_tick_gen #(.DIV(DIV)) u_tick (
      .clk  (Clk),
      .rst  (Rst),
      .clr  (go_load),
      .en   (en),
      .tick (tick)
   );
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         Ready <= 1'b1;
         Load <= 1'b0;
         Shift <= 1'b0;
         Busy <= 1'b0;
         Done <= 1'b0;
         DataOut <= '0;
         bits <= '0;
`ifdef SHIFT_CTRL_BUF_EN
         buf_word <= '0;
         buf_full <= 1'b0;
`endif
      end else begin
         Load <= go_load;
         Shift <= tick;
         Done <= state == SHIFT && last;
         Busy <= go_load || state == LOAD || (state == SHIFT && !last);
         bits <= go_load ? '0 : bits + BW'(tick);
`ifdef SHIFT_CTRL_BUF_EN
         Ready <= !full_next;
         buf_full <= full_next;
         if (store) buf_word <= Data;
         if (go_load) DataOut <= drain ? buf_word : Data;
`else
         Ready <= !go_load && (state == IDLE || state == DONE);
         if (go_load) DataOut <= Data;
`endif
         if (go_load) state <= LOAD;
         else
            case (state)
               LOAD:    state <= SHIFT;
               SHIFT:   state <= last ? DONE : SHIFT;
               default: state <= IDLE;
            endcase
      end
   end
endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: randomized and directed check of shift_ctrl (DIV=4 and DIV=1 instances) against a timing-window reference model
module tb_shift_ctrl;
`ifdef SHIFT_CTRL_BUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif
   localparam int SZ = 8;
   logic Clk = 1'b0;
   logic Rst, Valid;
   logic [7:0] Data;
   logic rdy [2], ld [2], sh [2], bz [2], dn [2];
   logic [7:0] dout [2];
   int checks = 0, errors = 0;
   int dv [2] = '{4, 1};
   bit act [2], mf [2];
   int d [2];
   logic [7:0] mo [2], mb [2];

   always #5 Clk = ~Clk;

   shift_ctrl #(.SIZE(SZ), .DIV(4)) u0 (
      .Clk(Clk), .Rst(Rst), .Valid(Valid), .Data(Data), .Ready(rdy[0]), .Load(ld[0]),
      .Shift(sh[0]), .DataOut(dout[0]), .Busy(bz[0]), .Done(dn[0])
   );
   shift_ctrl #(.SIZE(SZ), .DIV(1)) u1 (
      .Clk(Clk), .Rst(Rst), .Valid(Valid), .Data(Data), .Ready(rdy[1]), .Load(ld[1]),
      .Shift(sh[1]), .DataOut(dout[1]), .Busy(bz[1]), .Done(dn[1])
   );

   task automatic chk(input string tag, input int i, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s[div=%0d]: observed %0h expected %0h", tag, dv[i], got, exp);
      end
   endtask

   // model: d counts cycles since the accepting edge (d=1 is the Load cycle); the word ends at d=2+SIZE*DIV (Done)
   task automatic step();
      bit acc [2];
      bit idle, ended;
      int t;
      for (int i = 0; i < 2; i++) acc[i] = Valid && (BUF ? !mf[i] : !act[i]);
      @(posedge Clk);
      for (int i = 0; i < 2; i++) begin
         t = 2 + SZ * dv[i];
         if (Rst) begin
            act[i] = 0; d[i] = 0; mo[i] = 8'h00; mf[i] = 0;
         end else begin
            idle = !act[i];
            ended = act[i] && d[i] == t;
            if (mf[i] && (idle || ended)) begin
               act[i] = 1; d[i] = 1; mo[i] = mb[i]; mf[i] = 0;
            end else if (ended) act[i] = 0;
            else if (act[i]) d[i]++;
            if (acc[i]) begin
               if (idle) begin
                  act[i] = 1; d[i] = 1; mo[i] = Data;
               end else begin
                  mb[i] = Data; mf[i] = 1;
               end
            end
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         t = 2 + SZ * dv[i];
         chk("load", i, 8'(ld[i]), 8'(act[i] && d[i] == 1));
         chk("shift", i, 8'(sh[i]), 8'(act[i] && d[i] >= 2 && (d[i] - 1) % dv[i] == 0 && (d[i] - 1) / dv[i] <= SZ));
         chk("done", i, 8'(dn[i]), 8'(act[i] && d[i] == t));
         chk("busy", i, 8'(bz[i]), 8'(act[i] && d[i] < t));
         chk("ready", i, 8'(rdy[i]), 8'(BUF ? !mf[i] : !act[i]));
         chk("dataout", i, dout[i], mo[i]);
      end
   endtask

   initial begin
      Rst = 1'b1; Valid = 1'b0; Data = 8'h00;
      step();
      step();
      Rst = 1'b0;
      Valid = 1'b1; Data = 8'hA5;
      step();
      Valid = 1'b0; Data = 8'h00;
      repeat (40) step();
      Valid = 1'b1;
      repeat (80) begin
         Data = 8'($urandom);
         step();
      end
      Valid = 1'b0;
      repeat (40) step();
      Valid = 1'b1; Data = 8'h5A;
      step();
      Valid = 1'b0;
      repeat (11) step();
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      repeat (40) step();
      Rst = 1'b1; Valid = 1'b1; Data = 8'hC3;
      step();
      Rst = 1'b0; Valid = 1'b0;
      step();
      Valid = 1'b1; Data = 8'h11;
      step();
      Data = 8'h22;
      step();
      Valid = 1'b0;
      repeat (80) step();
      repeat (3000) begin
         Rst = $urandom_range(0, 149) == 0;
         Valid = $urandom_range(0, 3) != 0;
         Data = 8'($urandom);
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
